// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the zero
// register id and the bundle of pipeline-register controls.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Pipeline-register control bundle driven every cycle
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_freeze;
  } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports: clk, rst (async, active-high), inc (count enable), count (value).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Holds at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Scrubs the unreset pipeline
// registers after reset, inserts load-use bubbles, squashes on MEM redirects and
// freezes the back end during data-memory wait states.
// Ports:
//   clk, rst                      clock, async active-high reset
//   id_rs, id_rt, id_uses_rt      source operands of the ID instruction
//   idex_MemRead, idex_rt         load in EX and its destination
//   mem_redirect                  branch taken / jump in MEM
//   mem_req, dmem_ready           MEM access and its completion
//   pc_write .. pipe_freeze       pipeline register controls (combinational)
//   mem_timeout                   sticky memory wait timeout
//   stall_cnt, flush_cnt          saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned WAIT_MAX    = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             mem_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state, state_nxt;
  logic [INIT_W-1:0] init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  ctrl_t             ctrl;
  logic              load_use;
  logic              frozen;
  logic              stall_inc;
  logic              flush_inc;

  // Load in EX whose destination feeds the ID instruction; r0 never hazards
  assign load_use = idex_MemRead && (idex_rt != REG_ZERO) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and controls
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    frozen    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      ST_INIT: begin
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        // The release cycle of a wait behaves like RUN, so a held redirect is honoured
        if (!dmem_ready && ((state == ST_MEM_WAIT) || mem_req)) begin
          ctrl.pipe_freeze = 1'b1;
          frozen           = 1'b1;
          stall_inc        = 1'b1;
          state_nxt        = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
          if (mem_redirect) begin
            ctrl.pc_write    = 1'b1;
            ctrl.ifid_write  = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            flush_inc        = 1'b1;
          end else if (load_use) begin
            ctrl.idex_flush = 1'b1;
            stall_inc       = 1'b1;
          end else begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_write = 1'b1;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    if (rst) begin
      ctrl = '0;
    end
  end

  // Length of the post-reset scrub
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + INIT_W'(1);
    end else begin
      init_cnt <= '0;
    end
  end

  // Wait-state length and sticky timeout; counts frozen cycles spent in MEM_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if ((state == ST_MEM_WAIT) && frozen) begin
      if (wait_cnt != WAIT_W'(WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign pipe_freeze = ctrl.pipe_freeze;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned WAIT_MAX    = 16;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs = '0;
  logic [4:0]       id_rt = '0;
  logic             id_uses_rt = 1'b0;
  logic             idex_MemRead = 1'b0;
  logic [4:0]       idex_rt = '0;
  logic             mem_redirect = 1'b0;
  logic             mem_req = 1'b0;
  logic             dmem_ready = 1'b1;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic             pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, waiting flag, wait length, counters
  int since_rst = 0;
  bit waiting   = 1'b0;
  int wait_n    = 0;
  bit tmo       = 1'b0;
  int stalls    = 0;
  int flushes   = 0;

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .WAIT_MAX    (WAIT_MAX),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .idex_MemRead (idex_MemRead),
    .idex_rt      (idex_rt),
    .mem_redirect (mem_redirect),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pipe_freeze  (pipe_freeze),
    .mem_timeout  (mem_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= int'(CNT_MAX)) ? v : v + 1;
  endfunction

  function automatic int unsigned ctrl_vec();
    return {26'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze};
  endfunction

  // Reset the DUT and the model; during rst every output must be zero
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ctrl",  ctrl_vec(), 0);
    check_eq("rst_stall", 32'(stall_cnt), 0);
    check_eq("rst_flush", 32'(flush_cnt), 0);
    check_eq("rst_tmo",   32'(mem_timeout), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    since_rst = 0;
    waiting   = 1'b0;
    wait_n    = 0;
    tmo       = 1'b0;
    stalls    = 0;
    flushes   = 0;
  endtask

  // One pipeline cycle: apply inputs, check outputs, advance the model
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] xrt, input logic redir,
                       input logic req, input logic rdy);
    bit in_init, hazard, freeze;
    int unsigned exp_ctrl;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; idex_MemRead = mr; idex_rt = xrt;
    mem_redirect = redir; mem_req = req; dmem_ready = rdy;
    in_init = (since_rst < int'(INIT_CYCLES));
    hazard  = mr && (xrt != 5'd0) && ((xrt == rs) || (urt && (xrt == rt)));
    freeze  = !in_init && !rdy && (waiting || req);
    // bit order: pc_write ifid_write ifid_flush idex_flush exmem_flush pipe_freeze
    if (in_init)     exp_ctrl = 32'b001110;
    else if (freeze) exp_ctrl = 32'b000001;
    else if (redir)  exp_ctrl = 32'b111110;
    else if (hazard) exp_ctrl = 32'b000100;
    else             exp_ctrl = 32'b110000;
    @(negedge clk);
    check_eq("ctrl",      ctrl_vec(), exp_ctrl);
    check_eq("stall_cnt", 32'(stall_cnt), 32'(stalls));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(flushes));
    check_eq("timeout",   32'(mem_timeout), 32'(tmo));
    if (in_init) begin
      since_rst++;
    end else if (freeze) begin
      stalls = sat_inc(stalls);
      if (waiting) begin
        wait_n++;
        if (wait_n >= int'(WAIT_MAX)) tmo = 1'b1;
      end
      waiting = 1'b1;
    end else begin
      waiting = 1'b0;
      wait_n  = 0;
      if (redir)       flushes = sat_inc(flushes);
      else if (hazard) stalls  = sat_inc(stalls);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Post-reset scrub, then normal flow
    idle(INIT_CYCLES + 1);
    // Load-use on rs
    cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    idle(1);
    // r0 never hazards; rt match ignored when rt unused; rt match when used
    cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(5'd1, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    cycle(5'd1, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    // Redirect together with load-use
    cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    idle(1);
    // Three-cycle memory wait, redirect held across the freeze
    for (int i = 0; i < 3; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(2);
    // Long wait reaching the timeout; it stays set afterwards
    for (int i = 0; i < 20; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Reset in the middle of a wait restarts the scrub
    for (int i = 0; i < 5; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(INIT_CYCLES + 2);
    // Random traffic with occasional resets and long waits
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 4) != 0 || i % 400 < 30 ? (i % 400 >= 30) : 0));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
